// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU command sequencer: ALU control codes,
// sequencer state encoding and command field widths.
package alu_seq_ctrl_pkg;

   localparam logic [1:0] ALUC_ADD = 2'b00;
   localparam logic [1:0] ALUC_SUB = 2'b01;
   localparam logic [1:0] ALUC_AND = 2'b10;
   localparam logic [1:0] ALUC_OR  = 2'b11;

   localparam int OP_W = 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } seq_state_t;

   // A packed command is {op, rs, rt, rd}.
   function automatic int cmdWidth(input int aw);
      return OP_W + 3 * aw;
   endfunction

endpackage

// File: rtl/alu_seq_ctrl_fifo.sv
// seq_cmd_fifo: DEPTH-entry synchronous command FIFO with head-entry output.
// Pushes while full and pops while empty are ignored.
module seq_cmd_fifo #(
   parameter int DW    = 17,
   parameter int DEPTH = 2
) (
   input  logic          Clk,
   input  logic          Clr,
   input  logic          push,
   input  logic [DW-1:0] pushData,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [DW-1:0] head
);

   localparam int PW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] wrPtr;
   logic [PW:0]   count;
   logic          doPush;
   logic          doPop;

   assign full   = (count == (PW+1)'(DEPTH));
   assign empty  = (count == '0);
   assign head   = mem[rdPtr];
   assign doPush = push & ~full;
   assign doPop  = pop & ~empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            mem[wrPtr] <= pushData;
            wrPtr      <= wrPtr + PW'(1);
         end
         if (doPop) begin
            rdPtr <= rdPtr + PW'(1);
         end
         case ({doPush, doPop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: runs queued {op, rs, rt, rd} commands through a shared regfile/ALU
// as READ -> EXEC -> WB. Define ALU_SEQ_R0_PROTECT_EN to suppress writes to register 0.
module alu_seq_ctrl
   import alu_seq_ctrl_pkg::*;
#(
   parameter int W     = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 2
) (
   input  logic          Clk,
   input  logic          Clr,
   input  logic          Cmd_valid,
   output logic          Cmd_ready,
   input  logic [1:0]    Cmd_op,
   input  logic [AW-1:0] Cmd_rs,
   input  logic [AW-1:0] Cmd_rt,
   input  logic [AW-1:0] Cmd_rd,
   output logic [AW-1:0] Ra,
   output logic [AW-1:0] Rb,
   input  logic [W-1:0]  Qa,
   input  logic [W-1:0]  Qb,
   output logic [W-1:0]  X,
   output logic [W-1:0]  Y,
   output logic [1:0]    Aluc,
   input  logic [W-1:0]  R,
   input  logic          Z,
   output logic [AW-1:0] Wr,
   output logic [W-1:0]  D,
   output logic          We,
   output logic          Busy,
   output logic          Done,
   output logic          Done_z
);

   localparam int CW = cmdWidth(AW);

   seq_state_t    state;
   seq_state_t    stateNext;
   logic          popCmd;
   logic          fifoFull;
   logic          fifoEmpty;
   logic [CW-1:0] head;
   logic [1:0]    headOp;
   logic [AW-1:0] headRs;
   logic [AW-1:0] headRt;
   logic [AW-1:0] headRd;
   logic [1:0]    opCur;
   logic [AW-1:0] rdCur;
   logic          zReg;
   logic          weReg;
   logic          writeAllowed;

   seq_cmd_fifo #(
      .DW    (CW),
      .DEPTH (DEPTH)
   ) cmdFifo (
      .Clk      (Clk),
      .Clr      (Clr),
      .push     (Cmd_valid & Cmd_ready),
      .pushData ({Cmd_op, Cmd_rs, Cmd_rt, Cmd_rd}),
      .pop      (popCmd),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .head     (head)
   );

   assign {headOp, headRs, headRt, headRd} = head;
   assign Cmd_ready = ~fifoFull;
   assign Busy      = (state != S_IDLE) || !fifoEmpty;
   assign We        = weReg & ~Clr;

`ifdef ALU_SEQ_R0_PROTECT_EN
   assign writeAllowed = (rdCur != '0);
`else
   assign writeAllowed = 1'b1;
`endif

   always_ff @(posedge Clk) begin
      if (Clr) begin
         state <= S_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // WB pops straight into READ when work is queued, avoiding an IDLE bubble.
   always_comb begin
      stateNext = state;
      popCmd    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifoEmpty) begin
               popCmd    = 1'b1;
               stateNext = S_READ;
            end
         end
         S_READ:  stateNext = S_EXEC;
         S_EXEC:  stateNext = S_WB;
         S_WB: begin
            if (!fifoEmpty) begin
               popCmd    = 1'b1;
               stateNext = S_READ;
            end else begin
               stateNext = S_IDLE;
            end
         end
         default: stateNext = S_IDLE;
      endcase
   end

   // Each datapath output is loaded on the edge entering its state and then holds.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         opCur  <= '0;
         rdCur  <= '0;
         Ra     <= '0;
         Rb     <= '0;
         X      <= '0;
         Y      <= '0;
         Aluc   <= '0;
         Wr     <= '0;
         D      <= '0;
         zReg   <= 1'b0;
         weReg  <= 1'b0;
         Done   <= 1'b0;
         Done_z <= 1'b0;
      end else begin
         if (popCmd) begin
            opCur <= headOp;
            rdCur <= headRd;
            Ra    <= headRs;
            Rb    <= headRt;
         end
         if (state == S_READ) begin
            X    <= Qa;
            Y    <= Qb;
            Aluc <= opCur;
         end
         weReg <= 1'b0;
         if (state == S_EXEC) begin
            Wr    <= rdCur;
            D     <= R;
            zReg  <= Z;
            weReg <= writeAllowed;
         end
         Done <= (state == S_WB);
         if (state == S_WB) begin
            Done_z <= zReg;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural regfile and ALU around it.
// Expectations for register 0 follow ALU_SEQ_R0_PROTECT_EN.
module tb_alu_seq_ctrl;
   import alu_seq_ctrl_pkg::*;

   localparam int W     = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 2;

   logic          Clk = 1'b0;
   logic          Clr;
   logic          Cmd_valid;
   logic          Cmd_ready;
   logic [1:0]    Cmd_op;
   logic [AW-1:0] Cmd_rs, Cmd_rt, Cmd_rd;
   logic [AW-1:0] Ra, Rb, Wr;
   logic [W-1:0]  Qa, Qb, X, Y, R, D;
   logic [1:0]    Aluc;
   logic          Z, We, Busy, Done, Done_z;

   logic [W-1:0]  rf [32];
   logic          tbWe;
   logic [AW-1:0] tbWa;
   logic [W-1:0]  tbWd;

   int checks = 0;
   int passes = 0;

   alu_seq_ctrl #(.W(W), .AW(AW), .DEPTH(DEPTH)) dut (
      .Clk(Clk), .Clr(Clr), .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready),
      .Cmd_op(Cmd_op), .Cmd_rs(Cmd_rs), .Cmd_rt(Cmd_rt), .Cmd_rd(Cmd_rd),
      .Ra(Ra), .Rb(Rb), .Qa(Qa), .Qb(Qb), .X(X), .Y(Y), .Aluc(Aluc),
      .R(R), .Z(Z), .Wr(Wr), .D(D), .We(We), .Busy(Busy), .Done(Done),
      .Done_z(Done_z)
   );

   always #5 Clk = ~Clk;

   assign Qa = rf[Ra];
   assign Qb = rf[Rb];
   assign Z  = (R == '0);

   always_comb begin
      R = X + Y;
      case (Aluc)
         ALUC_SUB: R = X - Y;
         ALUC_AND: R = X & Y;
         ALUC_OR:  R = X | Y;
         default:  R = X + Y;
      endcase
   end

   // Bench preload port takes priority over the sequencer's write port.
   always @(posedge Clk) begin
      if (tbWe) rf[tbWa] <= tbWd;
      else if (We) rf[Wr] <= D;
   end

   task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] op,
                                input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                input logic [AW-1:0] rd);
      Cmd_valid = v;
      Cmd_op    = op;
      Cmd_rs    = rs;
      Cmd_rt    = rt;
      Cmd_rd    = rd;
   endtask

   function automatic logic [W-1:0] preloadVal(input int idx);
      case (idx)
         1: return 32'd12;
         2: return 32'd10;
         4: return 32'd5;
         5: return 32'd5;
         6: return 32'd77;
         9: return 32'd99;
         default: return 32'd0;
      endcase
   endfunction

   // One isolated command, checked cycle by cycle from accept through Done.
   task automatic runSingle(input string nm, input logic [1:0] op, input logic [AW-1:0] rs,
                            input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                            input logic [W-1:0] expX, input logic [W-1:0] expY,
                            input logic [W-1:0] expD, input logic expZ, input logic expWe);
      applyStimulus(1'b1, op, rs, rt, rd);
      checkOutput({nm, "_ready"}, Cmd_ready, 1);
      tick();
      applyStimulus(1'b0, 2'd0, '0, '0, '0);
      checkOutput({nm, "_busy_q"}, Busy, 1);
      tick();
      checkOutput({nm, "_ra"}, Ra, rs);
      checkOutput({nm, "_rb"}, Rb, rt);
      checkOutput({nm, "_we_read"}, We, 0);
      tick();
      checkOutput({nm, "_aluc"}, Aluc, op);
      checkOutput({nm, "_x"}, X, expX);
      checkOutput({nm, "_y"}, Y, expY);
      tick();
      checkOutput({nm, "_we_wb"}, We, expWe);
      checkOutput({nm, "_wr"}, Wr, rd);
      checkOutput({nm, "_d"}, D, expD);
      tick();
      checkOutput({nm, "_done"}, Done, 1);
      checkOutput({nm, "_done_z"}, Done_z, expZ);
      checkOutput({nm, "_we_after"}, We, 0);
      checkOutput({nm, "_busy_end"}, Busy, 0);
      tick();
      checkOutput({nm, "_done_once"}, Done, 0);
   endtask

   logic [AW-1:0] wbWr [8];
   logic [W-1:0]  wbD [8];
   int            doneCyc [8];
   logic          busyArr [40];
   logic [1:0]    bpOp [4];
   logic [AW-1:0] bpRd [4];
   logic [W-1:0]  bpExp [4];

   initial begin
      int wbN, doneN, k, lastWb, lw;
      logic prevWb7, sawNotReady, acc;
      logic [W-1:0] qaAfter;
      logic [AW-1:0] raAfter;

      tbWe = 1'b0; tbWa = '0; tbWd = '0;
      Clr = 1'b1;
      applyStimulus(1'b0, 2'd0, '0, '0, '0);
      for (int i = 0; i < 32; i++) begin
         tbWe = 1'b1; tbWa = AW'(i); tbWd = preloadVal(i);
         tick();
      end
      tbWe = 1'b0;
      Clr = 1'b0;
      #1;

      checkOutput("rst_ready", Cmd_ready, 1);
      checkOutput("rst_ra", Ra, 0);
      checkOutput("rst_rb", Rb, 0);
      checkOutput("rst_x", X, 0);
      checkOutput("rst_y", Y, 0);
      checkOutput("rst_aluc", Aluc, 0);
      checkOutput("rst_wr", Wr, 0);
      checkOutput("rst_d", D, 0);
      checkOutput("rst_we", We, 0);
      checkOutput("rst_busy", Busy, 0);
      checkOutput("rst_done", Done, 0);
      checkOutput("rst_done_z", Done_z, 0);

      runSingle("and", ALUC_AND, 5'd1, 5'd2, 5'd3, 32'd12, 32'd10, 32'd8, 1'b0, 1'b1);
      checkOutput("and_r3", rf[3], 8);
      runSingle("sub", ALUC_SUB, 5'd4, 5'd5, 5'd6, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1);
      checkOutput("sub_r6", rf[6], 0);

      // Back-to-back dependent commands.
      applyStimulus(1'b1, ALUC_ADD, 5'd1, 5'd2, 5'd7);
      tick();
      applyStimulus(1'b1, ALUC_ADD, 5'd7, 5'd7, 5'd8);
      checkOutput("raw_ready", Cmd_ready, 1);
      tick();
      applyStimulus(1'b0, 2'd0, '0, '0, '0);
      wbN = 0; doneN = 0; prevWb7 = 1'b0; qaAfter = '0; raAfter = '0;
      for (int i = 0; i < 20; i++) begin
         if (prevWb7) begin
            qaAfter = Qa;
            raAfter = Ra;
         end
         prevWb7 = We && (Wr == 5'd7);
         if (We && wbN < 8) begin wbWr[wbN] = Wr; wbD[wbN] = D; wbN++; end
         if (Done && doneN < 8) begin doneCyc[doneN] = i; doneN++; end
         tick();
      end
      checkOutput("raw_wb_count", wbN, 2);
      checkOutput("raw_wr0", wbWr[0], 7);
      checkOutput("raw_d0", wbD[0], 22);
      checkOutput("raw_ra_next", raAfter, 7);
      checkOutput("raw_qa_next", qaAfter, 22);
      checkOutput("raw_wr1", wbWr[1], 8);
      checkOutput("raw_d1", wbD[1], 44);
      checkOutput("raw_done_count", doneN, 2);
      checkOutput("raw_done_gap", doneCyc[1] - doneCyc[0], 3);
      checkOutput("raw_r8", rf[8], 44);

      // Backpressure: four commands offered continuously.
      bpOp[0] = ALUC_ADD; bpRd[0] = 5'd10; bpExp[0] = 32'd22;
      bpOp[1] = ALUC_SUB; bpRd[1] = 5'd11; bpExp[1] = 32'd2;
      bpOp[2] = ALUC_AND; bpRd[2] = 5'd12; bpExp[2] = 32'd8;
      bpOp[3] = ALUC_OR;  bpRd[3] = 5'd13; bpExp[3] = 32'd14;
      k = 0; wbN = 0; lastWb = -1; sawNotReady = 1'b0;
      applyStimulus(1'b1, bpOp[0], 5'd1, 5'd2, bpRd[0]);
      for (int i = 0; i < 40; i++) begin
         busyArr[i] = Busy;
         if (!Cmd_ready) sawNotReady = 1'b1;
         if (We) begin
            if (wbN < 8) begin wbWr[wbN] = Wr; wbD[wbN] = D; end
            wbN++;
            lastWb = i;
         end
         acc = Cmd_valid && Cmd_ready;
         tick();
         if (acc) begin
            k++;
            if (k < 4) applyStimulus(1'b1, bpOp[k], 5'd1, 5'd2, bpRd[k]);
            else applyStimulus(1'b0, 2'd0, '0, '0, '0);
         end
      end
      checkOutput("bp_accepted", k, 4);
      checkOutput("bp_ready_dropped", sawNotReady, 1);
      checkOutput("bp_wb_count", wbN, 4);
      for (int j = 0; j < 4; j++) begin
         checkOutput($sformatf("bp_wr%0d", j), wbWr[j], bpRd[j]);
         checkOutput($sformatf("bp_d%0d", j), wbD[j], bpExp[j]);
      end
      lw = (lastWb < 0 || lastWb > 38) ? 0 : lastWb;
      checkOutput("bp_busy_last_wb", busyArr[lw], 1);
      checkOutput("bp_busy_fall", busyArr[lw + 1], 0);
      checkOutput("bp_r13", rf[13], 14);

      // Reset during WB with a second command still queued.
      applyStimulus(1'b1, ALUC_OR, 5'd1, 5'd2, 5'd9);
      tick();
      applyStimulus(1'b1, ALUC_ADD, 5'd1, 5'd2, 5'd9);
      tick();
      applyStimulus(1'b0, 2'd0, '0, '0, '0);
      tick();
      tick();
      checkOutput("rst_mid_we_pre", We, 1);
      checkOutput("rst_mid_wr_pre", Wr, 9);
      Clr = 1'b1;
      #1;
      checkOutput("rst_mid_we_gated", We, 0);
      tick();
      Clr = 1'b0;
      #1;
      checkOutput("rst_mid_r9", rf[9], 99);
      checkOutput("rst_mid_ready", Cmd_ready, 1);
      checkOutput("rst_mid_busy", Busy, 0);
      checkOutput("rst_mid_done", Done, 0);
      checkOutput("rst_mid_d", D, 0);
      tick();
      tick();
      tick();
      checkOutput("rst_mid_busy_later", Busy, 0);
      checkOutput("rst_mid_r9_later", rf[9], 99);

`ifdef ALU_SEQ_R0_PROTECT_EN
      runSingle("r0", ALUC_ADD, 5'd1, 5'd2, 5'd0, 32'd12, 32'd10, 32'd22, 1'b0, 1'b0);
      checkOutput("r0_value", rf[0], 0);
`else
      runSingle("r0", ALUC_ADD, 5'd1, 5'd2, 5'd0, 32'd12, 32'd10, 32'd22, 1'b0, 1'b1);
      checkOutput("r0_value", rf[0], 22);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
